camera_capture: RTL and testbench

CAMERA_CAPTURE -- requirements
Module: camera_capture

---
 rtl/camera_capture.sv | 93 +++++++++
 tb/tb_camera_capture.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/camera_capture.sv
// camera_capture: turns a YUV422 camera byte stream into 1-bit thresholded framebuffer writes.
// Only luma is used; each Y/C byte pair yields one pixel written one cycle after the chroma byte.
module camera_capture #(
    parameter int ADDR_WIDTH = 15,
    parameter int H_PIXELS = 160,
    parameter int V_LINES = 120,
    parameter logic [7:0] THRESHOLD = 8'd128
) (
    input  logic                  pclk,
    input  logic                  reset_n,
    input  logic [7:0]            data_in,
    input  logic                  h_ref,
    input  logic                  v_sync,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic                  pixel,
    output logic                  frame_done
);
    localparam int CW = $clog2(2 * H_PIXELS + 1);
    localparam int LW = $clog2(V_LINES + 1);
    localparam logic [CW-1:0] H_COLS = CW'(H_PIXELS);
    localparam logic [LW-1:0] V_ROWS = LW'(V_LINES);
    localparam logic [ADDR_WIDTH-1:0] H_STEP = ADDR_WIDTH'(H_PIXELS);
    localparam logic [ADDR_WIDTH-1:0] BASE_MAX = ADDR_WIDTH'(V_LINES * H_PIXELS);

    typedef enum logic [1:0] {WAIT_FRAME, WAIT_LINE, BYTE_Y, BYTE_C} state_t;

    state_t                  state;
    logic                    seen_vs;
    logic [CW-1:0]           col;
    logic [LW-1:0]           line;
    logic [ADDR_WIDTH-1:0]   line_base;
    logic [7:0]              luma;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= WAIT_FRAME;
            seen_vs    <= 1'b0;
            we         <= 1'b0;
            write_addr <= '0;
            pixel      <= 1'b0;
            frame_done <= 1'b0;
            line       <= '0;
            col        <= '0;
            line_base  <= '0;
            luma       <= '0;
        end else begin
            we         <= 1'b0;
            frame_done <= 1'b0;
            if (state == WAIT_FRAME) begin
                if (v_sync) begin
                    seen_vs <= 1'b1;
                end else if (seen_vs) begin
                    seen_vs   <= 1'b0;
                    line      <= '0;
                    col       <= '0;
                    line_base <= '0;
                    state     <= WAIT_LINE;
                end
            end else if (v_sync) begin
                // an aborting v_sync already counts as the high half of the frame sync
                seen_vs    <= 1'b1;
                col        <= '0;
                frame_done <= line != '0;
                state      <= WAIT_FRAME;
            end else if (state == WAIT_LINE) begin
                if (h_ref) begin
                    luma  <= data_in;
                    col   <= '0;
                    state <= BYTE_C;
                end
            end else if (!h_ref) begin
                if (col != '0 && line < V_ROWS) begin
                    line      <= line + LW'(1);
                    line_base <= (line_base >= BASE_MAX - H_STEP) ? BASE_MAX : line_base + H_STEP;
                end
                col   <= '0;
                state <= WAIT_LINE;
            end else if (state == BYTE_Y) begin
                luma  <= data_in;
                state <= BYTE_C;
            end else begin
                if (col < H_COLS && line < V_ROWS) begin
                    we         <= 1'b1;
                    write_addr <= line_base + ADDR_WIDTH'(col);
                    pixel      <= luma >= THRESHOLD;
                end
                if (col != '1) col <= col + CW'(1);
                state <= BYTE_Y;
            end
        end
    end
endmodule

// File: tb/tb_camera_capture.sv
// tb_camera_capture: random YUV422 frames against a line/pixel-index model of the framebuffer writes.
module tb_camera_capture;
    localparam int H = 160;
    localparam int V = 120;
    localparam int TH = 128;

    typedef struct {
        int addr;
        bit pix;
        int cyc;
    } wr_t;

    logic        pclk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  data_in = 8'd0;
    logic        h_ref = 1'b0;
    logic        v_sync = 1'b0;
    logic        we;
    logic [14:0] write_addr;
    logic        pixel;
    logic        frame_done;

    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    wr_t exp_q[$];
    int  fd_q[$];
    wr_t e;
    int  last_addr = 0;
    bit  last_pix = 1'b0;
    bit  in_frame = 1'b0;
    int  line_idx = 0;

    camera_capture dut (
        .pclk(pclk),
        .reset_n(reset_n),
        .data_in(data_in),
        .h_ref(h_ref),
        .v_sync(v_sync),
        .we(we),
        .write_addr(write_addr),
        .pixel(pixel),
        .frame_done(frame_done)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge pclk) begin
        if (reset_n) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                check("we_missing", 32'(we), 1);
                e = exp_q.pop_front();
            end
            if (we) begin
                if (exp_q.size() == 0) begin
                    check("we_spurious", 32'(we), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("we_cycle", cyc, e.cyc);
                    check("write_addr", 32'(write_addr), e.addr);
                    check("pixel", 32'(pixel), 32'(e.pix));
                    last_addr = e.addr;
                    last_pix = e.pix;
                end
            end else begin
                check("addr_hold", 32'(write_addr), last_addr);
                check("pixel_hold", 32'(pixel), 32'(last_pix));
            end
            if (fd_q.size() > 0 && fd_q[0] < cyc) begin
                check("fd_missing", 32'(frame_done), 1);
                void'(fd_q.pop_front());
            end
            if (frame_done) begin
                if (fd_q.size() == 0) check("fd_spurious", 32'(frame_done), 0);
                else check("fd_cycle", cyc, fd_q.pop_front());
            end
        end
    end

    task automatic tick(input logic h, input logic v, input logic [7:0] d);
        @(posedge pclk);
        #1;
        h_ref = h;
        v_sync = v;
        data_in = d;
    endtask

    // yv < 0 selects random luma; keep leaves h_ref high with no line end
    task automatic send_line(input int nbytes, input int yv, input bit keep);
        logic [7:0] y;
        int p;
        y = 8'd0;
        p = 0;
        for (int b = 0; b < nbytes; b++) begin
            if (b % 2 == 0) begin
                y = (yv < 0) ? 8'($urandom) : 8'(yv);
                tick(1'b1, 1'b0, y);
            end else begin
                tick(1'b1, 1'b0, 8'($urandom));
                if (in_frame && p < H && line_idx < V)
                    exp_q.push_back('{line_idx * H + p, y >= 8'(TH), cyc + 1});
                p++;
            end
        end
        if (!keep) begin
            tick(1'b0, 1'b0, 8'($urandom));
            tick(1'b0, 1'b0, 8'($urandom));
            if (in_frame && p > 0) line_idx++;
        end
    endtask

    task automatic frame_sync(input logic h);
        tick(h, 1'b1, 8'($urandom));
        if (in_frame && line_idx > 0) fd_q.push_back(cyc + 1);
        tick(1'b0, 1'b1, 8'd0);
        tick(1'b0, 1'b0, 8'd0);
        tick(1'b0, 1'b0, 8'd0);
        in_frame = 1'b1;
        line_idx = 0;
    endtask

    task automatic drain(input string tag);
        repeat (3) tick(1'b0, 1'b0, 8'd0);
        check({tag, "_pending_wr"}, exp_q.size(), 0);
        check({tag, "_pending_fd"}, fd_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check("rst_we", 32'(we), 0);
        check("rst_addr", 32'(write_addr), 0);
        check("rst_pixel", 32'(pixel), 0);
        check("rst_fd", 32'(frame_done), 0);
        tick(1'b0, 1'b0, 8'd0);
        reset_n = 1'b1;
        send_line(320, -1, 1'b0);
        drain("no_vsync");
        frame_sync(1'b0);
        send_line(320, 8'hFF, 1'b0);
        drain("white_line");
        frame_sync(1'b0);
        for (int l = 0; l < V; l++) send_line(320, 8'h7F, 1'b0);
        frame_sync(1'b0);
        drain("full_frame");
        for (int l = 0; l < 3; l++) send_line(320, -1, 1'b0);
        send_line(400, -1, 1'b0);
        send_line(320, -1, 1'b0);
        frame_sync(1'b0);
        drain("long_line");
        send_line(101, -1, 1'b0);
        send_line(1, -1, 1'b0);
        send_line(320, TH, 1'b0);
        send_line(320, TH - 1, 1'b0);
        for (int l = 0; l < 6; l++) send_line($urandom_range(0, 400), -1, 1'b0);
        frame_sync(1'b0);
        drain("odd_random");
        for (int l = 0; l < 118; l++) send_line(4, -1, 1'b0);
        for (int l = 118; l < 130; l++) send_line(320, -1, 1'b0);
        frame_sync(1'b0);
        drain("overflow");
        send_line(320, -1, 1'b0);
        send_line(21, -1, 1'b1);
        frame_sync(1'b1);
        drain("abort");
        send_line(20, -1, 1'b1);
        @(posedge pclk);
        @(negedge pclk);
        #1;
        reset_n = 1'b0;
        h_ref = 1'b0;
        #1;
        check("async_rst_we", 32'(we), 0);
        check("async_rst_addr", 32'(write_addr), 0);
        check("async_rst_pixel", 32'(pixel), 0);
        check("async_rst_fd", 32'(frame_done), 0);
        exp_q.delete();
        fd_q.delete();
        last_addr = 0;
        last_pix = 1'b0;
        in_frame = 1'b0;
        line_idx = 0;
        tick(1'b0, 1'b0, 8'd0);
        tick(1'b0, 1'b0, 8'd0);
        reset_n = 1'b1;
        send_line(320, -1, 1'b0);
        frame_sync(1'b0);
        send_line(320, -1, 1'b0);
        send_line(320, -1, 1'b0);
        frame_sync(1'b0);
        drain("after_reset");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
